cdb_arbiter: RTL and testbench

Round-robin arbiter for the Common Data Bus (CDB) of the Tomasulo datapath. Up to `N_REQ` functional units raise a write request carrying a 16-bit result and a reservation-station tag. Each cycle the arbiter picks one request and drives it on the registered CDB outputs, where the register file and reservation stations snoop it. It returns a one-cycle one-hot grant so the winning unit can release its result.

---
 rtl/cdb_arbiter.sv | 112 +++++++++++
 tb/tb_cdb_arbiter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter driving the registered Common Data Bus.
// One broadcast per cycle; last winner is masked for one arbitration.
module cdb_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 16,
  parameter int TAG_W  = 3
) (
  input  logic                      Clock,
  input  logic                      Resetn,
  input  logic                      Clear,
  input  logic [N_REQ-1:0]          Req,
  input  logic [N_REQ*DATA_W-1:0]   Req_Data,
  input  logic [N_REQ*TAG_W-1:0]    Req_Tag,
  output logic [N_REQ-1:0]          Grant,
  output logic                      CDB_Valid,
  output logic [DATA_W-1:0]         CDB_Data,
  output logic [TAG_W-1:0]          CDB_Tag,
  output logic                      Conflict
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]  grant_q, grant_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              conflict_q, conflict_d;
  logic [PW-1:0]     prio_q, prio_d;

  logic [N_REQ-1:0]  elig;
  logic [PW-1:0]     win;
  logic              found;
  logic              seen1;
  logic              seen2;
  int                idx;

  always_comb begin
    elig  = Req & ~grant_q;
    win   = '0;
    found = 1'b0;
    seen1 = 1'b0;
    seen2 = 1'b0;
    idx   = 0;

    for (int k = 0; k < N_REQ; k++) begin
      if (elig[k]) begin
        if (seen1) seen2 = 1'b1;
        seen1 = 1'b1;
      end
    end

    // Walk from prio_q upward, wrapping, and take the first eligible.
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(prio_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end

    grant_d    = '0;
    valid_d    = 1'b0;
    data_d     = data_q;
    tag_d      = tag_q;
    conflict_d = seen2;
    prio_d     = prio_q;

    if (found) begin
      grant_d = N_REQ'(1) << win;
      valid_d = 1'b1;
      data_d  = Req_Data[int'(win)*DATA_W +: DATA_W];
      tag_d   = Req_Tag[int'(win)*TAG_W +: TAG_W];
      if (int'(win) == N_REQ - 1) prio_d = '0;
      else                        prio_d = win + PW'(1);
    end

    if (Clear) begin
      grant_d    = '0;
      valid_d    = 1'b0;
      data_d     = '0;
      tag_d      = '0;
      conflict_d = 1'b0;
      prio_d     = '0;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      grant_q    <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      tag_q      <= '0;
      conflict_q <= 1'b0;
      prio_q     <= '0;
    end else begin
      grant_q    <= grant_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      tag_q      <= tag_d;
      conflict_q <= conflict_d;
      prio_q     <= prio_d;
    end
  end

  assign Grant     = grant_q;
  assign CDB_Valid = valid_q;
  assign CDB_Data  = data_q;
  assign CDB_Tag   = tag_q;
  assign Conflict  = conflict_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scoreboard bench for cdb_arbiter.
// Expected broadcasts are queued at drive time, popped after each edge.
module tb_cdb_arbiter;

  typedef struct packed {
    logic [3:0]  g;
    logic        v;
    logic [15:0] d;
    logic [2:0]  t;
    logic        c;
  } exp_t;

  logic        Clock;
  logic        Resetn;
  logic        Clear;
  logic [3:0]  Req;
  logic [63:0] Req_Data;
  logic [11:0] Req_Tag;
  logic [3:0]  Grant;
  logic        CDB_Valid;
  logic [15:0] CDB_Data;
  logic [2:0]  CDB_Tag;
  logic        Conflict;

  int   checks;
  int   errors;
  int   step;
  exp_t sb[$];

  cdb_arbiter #(.N_REQ(4), .DATA_W(16), .TAG_W(3)) dut (
    .Clock(Clock), .Resetn(Resetn), .Clear(Clear),
    .Req(Req), .Req_Data(Req_Data), .Req_Tag(Req_Tag),
    .Grant(Grant), .CDB_Valid(CDB_Valid), .CDB_Data(CDB_Data),
    .CDB_Tag(CDB_Tag), .Conflict(Conflict)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] g, input logic v,
                              input logic [15:0] d, input logic [2:0] t,
                              input logic c);
    exp_t e;
    e.g = g; e.v = v; e.d = d; e.t = t; e.c = c;
    return e;
  endfunction

  task automatic cyc(input logic [3:0] r, input logic clr, input exp_t e);
    exp_t o;
    @(negedge Clock);
    Req   = r;
    Clear = clr;
    sb.push_back(e);
    @(posedge Clock);
    #1;
    step++;
    if (sb.size() == 0) begin
      chk($sformatf("s%0d_sb_empty", step), 32'd0, 32'd1);
    end else begin
      o = sb.pop_front();
      chk($sformatf("s%0d_grant", step), 32'(Grant), 32'(o.g));
      chk($sformatf("s%0d_valid", step), 32'(CDB_Valid), 32'(o.v));
      chk($sformatf("s%0d_data", step), 32'(CDB_Data), 32'(o.d));
      chk($sformatf("s%0d_tag", step), 32'(CDB_Tag), 32'(o.t));
      chk($sformatf("s%0d_conf", step), 32'(Conflict), 32'(o.c));
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_grant"}, 32'(Grant), 32'd0);
    chk({tag, "_valid"}, 32'(CDB_Valid), 32'd0);
    chk({tag, "_data"}, 32'(CDB_Data), 32'd0);
    chk({tag, "_tag"}, 32'(CDB_Tag), 32'd0);
    chk({tag, "_conf"}, 32'(Conflict), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    step   = 0;
    Resetn = 1'b0;
    Clear  = 1'b0;
    Req    = 4'b0000;
    Req_Data = {16'h3333, 16'h00A5, 16'h1234, 16'h1111};
    Req_Tag  = {3'd3, 3'd5, 3'd2, 3'd1};
    #2;
    chk_zero("por");
    @(negedge Clock);
    Resetn = 1'b1;

    cyc(4'b0000, 1'b0, mk(4'b0000, 0, 16'h0000, 3'd0, 0));
    cyc(4'b0100, 1'b0, mk(4'b0100, 1, 16'h00A5, 3'd5, 0));
    cyc(4'b0000, 1'b0, mk(4'b0000, 0, 16'h00A5, 3'd5, 0));
    // wrap: unit 2 last, so 3 then 0
    cyc(4'b1001, 1'b0, mk(4'b1000, 1, 16'h3333, 3'd3, 1));
    cyc(4'b0001, 1'b0, mk(4'b0001, 1, 16'h1111, 3'd1, 0));
    cyc(4'b0000, 1'b0, mk(4'b0000, 0, 16'h1111, 3'd1, 0));
    // clear with all pending beats arbitration
    cyc(4'b1111, 1'b1, mk(4'b0000, 0, 16'h0000, 3'd0, 0));
    cyc(4'b1111, 1'b0, mk(4'b0001, 1, 16'h1111, 3'd1, 1));
    cyc(4'b1110, 1'b0, mk(4'b0010, 1, 16'h1234, 3'd2, 1));
    cyc(4'b1100, 1'b0, mk(4'b0100, 1, 16'h00A5, 3'd5, 1));
    cyc(4'b1000, 1'b0, mk(4'b1000, 1, 16'h3333, 3'd3, 0));
    cyc(4'b0000, 1'b0, mk(4'b0000, 0, 16'h3333, 3'd3, 0));
    // prio back at 0: 1001 must pick unit 0
    cyc(4'b1001, 1'b0, mk(4'b0001, 1, 16'h1111, 3'd1, 1));
    cyc(4'b1000, 1'b0, mk(4'b1000, 1, 16'h3333, 3'd3, 0));
    // held request alternates
    cyc(4'b0010, 1'b0, mk(4'b0010, 1, 16'h1234, 3'd2, 0));
    cyc(4'b0010, 1'b0, mk(4'b0000, 0, 16'h1234, 3'd2, 0));
    cyc(4'b0010, 1'b0, mk(4'b0010, 1, 16'h1234, 3'd2, 0));
    cyc(4'b0010, 1'b0, mk(4'b0000, 0, 16'h1234, 3'd2, 0));
    // continuous all-request from prio 2
    cyc(4'b1111, 1'b0, mk(4'b0100, 1, 16'h00A5, 3'd5, 1));
    cyc(4'b1111, 1'b0, mk(4'b1000, 1, 16'h3333, 3'd3, 1));
    cyc(4'b1111, 1'b0, mk(4'b0001, 1, 16'h1111, 3'd1, 1));
    cyc(4'b1111, 1'b0, mk(4'b0010, 1, 16'h1234, 3'd2, 1));
    cyc(4'b1111, 1'b0, mk(4'b0100, 1, 16'h00A5, 3'd5, 1));

    // async reset in the middle of a broadcast
    chk("pre_rst_valid", 32'(CDB_Valid), 32'd1);
    #2;
    Resetn = 1'b0;
    Req    = 4'b0000;
    #1;
    chk_zero("async");
    @(negedge Clock);
    Resetn = 1'b1;
    cyc(4'b0000, 1'b0, mk(4'b0000, 0, 16'h0000, 3'd0, 0));
    cyc(4'b0011, 1'b0, mk(4'b0001, 1, 16'h1111, 3'd1, 1));
    cyc(4'b0010, 1'b0, mk(4'b0010, 1, 16'h1234, 3'd2, 0));
    cyc(4'b0000, 1'b0, mk(4'b0000, 0, 16'h1234, 3'd2, 0));

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
